// File: rtl/hdb3_tdm_scheduler_if.sv
// Bundle between the TDM frame scheduler and its users: the channel request
// side (enable, request flags, bytes) and the serial/status side toward the
// HDB3 encoder.
interface hdb3_tdm_scheduler_if #(
   parameter int NCH = 4
);
   logic             i_en;
   logic [NCH-1:0]   i_req;
   logic [8*NCH-1:0] i_byte;
   logic [NCH-1:0]   o_ack;
   logic             o_data;
   logic             o_frame;
   logic [3:0]       o_slot;
   logic             o_busy;

   modport master (
      output i_en, i_req, i_byte,
      input  o_ack, o_data, o_frame, o_slot, o_busy
   );

   modport slave (
      input  i_en, i_req, i_byte,
      output o_ack, o_data, o_frame, o_slot, o_busy
   );
endinterface

// File: rtl/hdb3_tdm_scheduler.sv
// TDM frame scheduler feeding one HDB3 encoder, one bit per clock.
// Frame = SYNC byte followed by NCH channel slots, each byte MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame in progress, o_data held low, waiting for i_en
// ST_SYNC | shifting out the SYNC byte (slot 0)
// ST_SLOT | shifting out a channel byte or IDLE_BYTE filler (slot 1..NCH)
module hdb3_tdm_scheduler #(
   parameter int         NCH       = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hE4,
   parameter logic [7:0] IDLE_BYTE = 8'h00
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   hdb3_tdm_scheduler_if.slave    bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_SLOT} state_t;

   state_t         r_state;
   logic [2:0]     r_bit_cnt;
   logic [3:0]     r_slot_cnt;
   logic [7:0]     r_shift;
   logic           r_data;
   logic           r_frame;
   logic [3:0]     r_slot;
   logic           r_busy;
   logic [NCH-1:0] r_ack;

   logic           w_req_sel;
   logic [7:0]     w_byte_sel;
   logic [NCH-1:0] w_ack_sel;
   logic           w_last_slot;

   // Pick the request/byte of the channel whose slot comes next (slot_cnt+1
   // maps to channel slot_cnt); only consulted on the last bit of a byte.
   always_comb begin
      w_req_sel  = 1'b0;
      w_byte_sel = IDLE_BYTE;
      w_ack_sel  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (r_slot_cnt == 4'(k)) begin
            w_req_sel    = bus.i_req[k];
            w_byte_sel   = bus.i_byte[8*k +: 8];
            w_ack_sel[k] = 1'b1;
         end
      end
   end

   assign w_last_slot = (r_slot_cnt == 4'(NCH));

   // Frame sequencer: bit shifting, slot loading and frame restart/stop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_slot_cnt <= 4'd0;
         r_shift    <= 8'd0;
         r_data     <= 1'b0;
         r_frame    <= 1'b0;
         r_slot     <= 4'hF;
         r_busy     <= 1'b0;
         r_ack      <= '0;
      end else begin
         r_ack   <= '0;
         r_frame <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_data <= 1'b0;
               r_busy <= 1'b0;
               r_slot <= 4'hF;
               if (bus.i_en) begin
                  r_state    <= ST_SYNC;
                  r_data     <= SYNC_BYTE[7];
                  r_shift    <= {SYNC_BYTE[6:0], 1'b0};
                  r_frame    <= 1'b1;
                  r_slot     <= 4'd0;
                  r_busy     <= 1'b1;
                  r_bit_cnt  <= 3'd0;
                  r_slot_cnt <= 4'd0;
               end
            end
            ST_SYNC, ST_SLOT: begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt != 3'd7) begin
                  r_data  <= r_shift[7];
                  r_shift <= {r_shift[6:0], 1'b0};
               end else if (!w_last_slot) begin
                  r_state    <= ST_SLOT;
                  r_slot_cnt <= r_slot_cnt + 4'd1;
                  r_slot     <= r_slot_cnt + 4'd1;
                  if (w_req_sel) begin
                     r_ack   <= w_ack_sel;
                     r_data  <= w_byte_sel[7];
                     r_shift <= {w_byte_sel[6:0], 1'b0};
                  end else begin
                     r_data  <= IDLE_BYTE[7];
                     r_shift <= {IDLE_BYTE[6:0], 1'b0};
                  end
               end else if (bus.i_en) begin
                  // back-to-back frame, no gap bit between frames
                  r_state    <= ST_SYNC;
                  r_slot_cnt <= 4'd0;
                  r_slot     <= 4'd0;
                  r_frame    <= 1'b1;
                  r_data     <= SYNC_BYTE[7];
                  r_shift    <= {SYNC_BYTE[6:0], 1'b0};
               end else begin
                  r_state    <= ST_IDLE;
                  r_slot_cnt <= 4'd0;
                  r_slot     <= 4'hF;
                  r_busy     <= 1'b0;
                  r_data     <= 1'b0;
                  r_shift    <= 8'd0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_ack   = r_ack;
   assign bus.o_data  = r_data;
   assign bus.o_frame = r_frame;
   assign bus.o_slot  = r_slot;
   assign bus.o_busy  = r_busy;

endmodule

// File: tb/tb_hdb3_tdm_scheduler.sv
// Scoreboard bench for the TDM frame scheduler: the driver builds each frame
// from its byte list and queues the expected per-cycle outputs; the monitor
// compares every cycle, expecting idle outputs whenever nothing is queued.
module tb_hdb3_tdm_scheduler;
   localparam int NCH  = 4;
   localparam int FLEN = 8 * (NCH + 1);

   typedef struct {
      logic       data;
      logic       frame;
      logic [3:0] slot;
      logic       busy;
      logic [3:0] ack;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   hdb3_tdm_scheduler_if #(.NCH(NCH)) bus ();

   hdb3_tdm_scheduler #(.NCH(NCH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endfunction

   // Reference: a frame is the byte list {SYNC, ch0..chN-1 or 00}, sent MSB
   // first; a served channel acks on the first bit of its slot.
   function automatic void push_frame(input logic [NCH-1:0] rq, input logic [8*NCH-1:0] bt);
      logic [7:0] fb [NCH+1];
      exp_t e;
      fb[0] = 8'hE4;
      for (int k = 0; k < NCH; k++) fb[k+1] = rq[k] ? bt[8*k +: 8] : 8'h00;
      for (int c = 0; c < FLEN; c++) begin
         e.data  = fb[c/8][7 - (c%8)];
         e.frame = (c == 0);
         e.slot  = 4'(c/8);
         e.busy  = 1'b1;
         e.ack   = 4'd0;
         if ((c % 8) == 0 && c >= 8 && rq[c/8 - 1]) e.ack = 4'(1 << (c/8 - 1));
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: one comparison set per cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else begin
         mon_e.data = 1'b0; mon_e.frame = 1'b0; mon_e.slot = 4'hF;
         mon_e.busy = 1'b0; mon_e.ack = 4'd0;
      end
      chk("o_data",  32'(bus.o_data),  32'(mon_e.data));
      chk("o_frame", 32'(bus.o_frame), 32'(mon_e.frame));
      chk("o_slot",  32'(bus.o_slot),  32'(mon_e.slot));
      chk("o_busy",  32'(bus.o_busy),  32'(mon_e.busy));
      chk("o_ack",   32'(bus.o_ack),   32'(mon_e.ack));
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_abort();
      rst = 1'b1;
      exp_q.delete();
      #2;
      chk("async_busy", 32'(bus.o_busy), 32'd0);
      chk("async_slot", 32'(bus.o_slot), 32'hF);
      chk("async_ack",  32'(bus.o_ack),  32'd0);
      bus.i_req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // mode 0: no requests, 1: ch2=A5, 2: all 11/22/33/44, 3: random.
   // i_en drops at cycle 10 of the last frame; abort_cyc>=0 resets there.
   task automatic run(input int nframes, input int mode, input int abort_cyc);
      logic [NCH-1:0]   rq;
      logic [8*NCH-1:0] bt;
      bus.i_en = 1'b1;
      @(posedge clk);
      #1;
      for (int f = 0; f < nframes; f++) begin
         case (mode)
            0:       begin rq = '0;      bt = $urandom; end
            1:       begin rq = 4'b0100; bt = 32'h00A5_0000; end
            2:       begin rq = 4'b1111; bt = 32'h4433_2211; end
            default: begin rq = 4'($urandom); bt = $urandom; end
         endcase
         bus.i_req  = rq;
         bus.i_byte = bt;
         push_frame(rq, bt);
         for (int c = 0; c < FLEN; c++) begin
            if (f == nframes - 1 && c == 10) bus.i_en = 1'b0;
            if (f == nframes - 1 && c == abort_cyc) begin
               do_abort();
               return;
            end
            @(posedge clk);
            #1;
         end
      end
      bus.i_req = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.i_en   = 1'b0;
      bus.i_req  = '0;
      bus.i_byte = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(20);
      run(2, 0, -1);
      idle(3);
      run(1, 1, -1);
      idle(2);
      run(1, 2, -1);
      idle(2);
      run(4, 3, -1);
      idle(20);
      run(1, 2, 27);
      run(3, 3, -1);
      idle(10);
      run(6, 3, -1);
      idle(5);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hdb3_tdm_scheduler.md
Name: hdb3_tdm_scheduler

Overview:
- Time-division frame scheduler that sequences the serial bit stream into the HDB3 encoder.
- Shares the single encoder between NCH byte-oriented requesters.
- Emits one bit per i_clk cycle, since the encoder consumes i_data every clock.
- Frame format: SYNC byte, then NCH channel slots of 8 bits, MSB first. A slot with no pending request carries IDLE_BYTE.

Parameters:
- NCH, 4, number of requesting channels (1..8)
- SYNC_BYTE, 8'hE4, framing pattern sent at the start of every frame
- IDLE_BYTE, 8'h00, filler for empty slots (deliberately all-zero to exercise V/B substitution downstream)

Ports:
- i_clk  in  1  system clock; one encoder bit per cycle
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  scheduler enable; frames start only while high
- i_req  in  NCH  per-channel byte-pending flag
- i_byte  in  8*NCH  channel bytes; channel k occupies bits [8k+7:8k]
- o_ack  out  NCH  one-cycle pulse when channel k's byte is captured
- o_data  out  1  serial bit to encoder i_data
- o_frame  out  1  high during the first SYNC bit of each frame
- o_slot  out  4  current slot: 0 = SYNC, k+1 = channel k; 4'hF when idle
- o_busy  out  1  high while a frame is in progress

Behaviour:
- Reset values:
  - o_data=0, o_ack=0, o_frame=0, o_slot=4'hF, o_busy=0
  - state=IDLE, bit_cnt=0, slot_cnt=0, shift register=0
- Reset asserted mid-frame aborts immediately. No partial byte resumes, and no o_ack is issued for the aborted slot.
- All outputs are registered.
- FSM states: IDLE, SYNC, SLOT.
- IDLE:
  - o_data=0, o_busy=0, o_slot=4'hF.
  - On the edge where i_en=1: go to SYNC, load SYNC_BYTE, o_data<=SYNC_BYTE[7], o_frame<=1, o_slot<=0, o_busy<=1, bit_cnt<=0.
- SYNC and SLOT:
  - Each edge shifts the next bit, MSB first, into o_data and increments bit_cnt (3-bit, wraps 7->0).
  - o_frame is high only for the first SYNC bit.
- Slot load, on the edge where bit_cnt==7 (last bit of the current byte):
  - Next slot index n = slot_cnt+1, where slot_cnt 0 = SYNC.
  - If n<=NCH, go to/stay in SLOT and set o_slot<=n.
  - If i_req[n-1]=1: capture i_byte of channel n-1, set o_ack[n-1]<=1 for exactly one cycle, and o_data<=captured[7].
  - Otherwise: load IDLE_BYTE, no ack.
  - i_req and i_byte are sampled only on this edge. A requester must hold both until its ack. A request dropped before its slot edge is not served.
- End of frame, on bit_cnt==7 in slot NCH:
  - If i_en=1: start a new frame back-to-back (SYNC, o_frame<=1). No gap bit.
  - If i_en=0: go to IDLE. o_data<=0, o_busy<=0, o_slot<=4'hF on that edge.
  - i_en falling mid-frame never truncates a frame; the current frame always completes.
- Frame length is exactly 8*(NCH+1) cycles. The first SYNC bit appears on o_data one cycle after the edge that sampled i_en=1.
- o_ack is one-hot or zero.
- A channel with i_req held continuously is served once per frame, in fixed slot order. There is no starvation because slots are TDM.
- Channel ack latency after i_req rises: at most 8*(NCH+1) cycles.

Test Plan:
- Reset, i_en=0, 20 cycles -> o_data=0, o_busy=0, o_slot=F, o_ack=0 throughout.
- NCH=4, i_en=1 held, all i_req=0 -> o_frame pulses every 40 cycles. Each frame bits are 11100100 followed by 32 zeros. o_ack never asserts.
- i_req[2]=1 with byte 8'hA5, held until ack -> o_ack[2] pulses on the edge entering slot 3, i.e. cycle 24 of the frame. Bits 24..31 = 10100101. Other slots carry 0.
- All i_req=1, bytes 11,22,33,44 -> acks in order 0,1,2,3, spaced 8 cycles apart. Serial output = E4 11 22 33 44.
- i_en dropped at cycle 10 of a frame -> the frame completes all 40 bits, then o_busy=0. No new o_frame.
- i_rst pulsed at cycle 27 while slot 3 is active -> outputs reset asynchronously. No o_ack[3]. After release with i_en=1, a fresh frame starts at SYNC.
